despacho_ctrl: RTL and testbench

DESPACHO_CTRL -- requirements
Module: despacho_ctrl

---
 rtl/despacho_pkg.sv | 33 +++
 rtl/cola_pedidos.sv | 67 ++++++
 rtl/despacho_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_despacho_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/despacho_pkg.sv
// Shared encodings and default sizing for the order-dispatch controller.
package despacho_pkg;

  localparam int DEF_PRODUCTS        = 4;
  localparam int DEF_DEPTH           = 4;
  localparam int DEF_DISPENSE_CYCLES = 8;

  typedef enum logic [1:0] {
    E_IDLE    = 2'd0,
    E_SELECT  = 2'd1,
    E_CONFIRM = 2'd2
  } entry_state_t;

  typedef enum logic [1:0] {
    D_IDLE     = 2'd0,
    D_DISPENSE = 2'd1,
    D_DONE     = 2'd2
  } deliv_state_t;

  // Modular step of a product code in the range 0..n-1, up or down.
  function automatic int unsigned wrap_step(input int unsigned code,
                                            input int unsigned n,
                                            input logic        down);
    int unsigned r;
    if (down) begin
      r = (code == 32'd0) ? (n - 32'd1) : (code - 32'd1);
    end else begin
      r = ((code + 32'd1) >= n) ? 32'd0 : (code + 32'd1);
    end
    return r;
  endfunction

endpackage

// File: rtl/cola_pedidos.sv
// Order FIFO: first-word fall-through head, push refused while full.
module cola_pedidos #(
  parameter  int DEPTH = 4,
  parameter  int W     = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int QW    = $clog2(DEPTH) + 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [QW-1:0] count,
  output logic          full
);

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_next_s;
  logic [AW-1:0] rd_ptr_next_s;
  logic [QW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Qualify requests and compute wrapped pointer increments.
  always_comb begin
    push_ok_s     = push && (count_r != QW'(DEPTH));
    pop_ok_s      = pop && (count_r != {QW{1'b0}});
    wr_ptr_next_s = (wr_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : (wr_ptr_r + AW'(1));
    rd_ptr_next_s = (rd_ptr_r == AW'(DEPTH - 1)) ? {AW{1'b0}} : (rd_ptr_r + AW'(1));
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {QW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_next_s;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_next_s;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + QW'(1);
        2'b01:   count_r <= count_r - QW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == QW'(DEPTH));

endmodule

// File: rtl/despacho_ctrl.sv
// Vending-style order controller: button-driven order entry feeding a FIFO,
// drained by a fixed-duration dispense sequencer.
module despacho_ctrl
  import despacho_pkg::*;
#(
  parameter  int PRODUCTS        = DEF_PRODUCTS,
  parameter  int DEPTH           = DEF_DEPTH,
  parameter  int DISPENSE_CYCLES = DEF_DISPENSE_CYCLES,
  localparam int SW              = (PRODUCTS > 1) ? $clog2(PRODUCTS) : 1,
  localparam int QW              = $clog2(DEPTH) + 1
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_next,
  input  logic          btn_back,
  input  logic          btn_ok,
  input  logic          btn_cancel,
  output logic [SW-1:0] sel_product,
  output logic [1:0]    entry_state,
  output logic [QW-1:0] queue_count,
  output logic          queue_full,
  output logic          dispense_active,
  output logic [SW-1:0] dispense_product,
  output logic          order_done,
  output logic          reject
);

  localparam int CW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

  logic [3:0]    btn_s;
  logic [3:0]    btn_prev_r;
  logic [3:0]    ev_s;
  logic          act_next_s;
  logic          act_back_s;
  logic          act_ok_s;
  logic          act_cancel_s;

  entry_state_t  e_state_r;
  entry_state_t  e_state_next_s;
  logic [SW-1:0] sel_r;
  logic [SW-1:0] sel_next_s;
  logic          push_s;
  logic          reject_s;
  logic          reject_r;

  deliv_state_t  d_state_r;
  deliv_state_t  d_state_next_s;
  logic [CW-1:0] d_cnt_r;
  logic [CW-1:0] d_cnt_next_s;
  logic          pop_s;
  logic [SW-1:0] disp_prod_r;
  logic          disp_active_r;
  logic          order_done_r;

  logic [SW-1:0] fifo_dout_s;
  logic [QW-1:0] fifo_count_s;
  logic          fifo_full_s;

  assign btn_s = {btn_cancel, btn_ok, btn_back, btn_next};

  // Previous button levels; reset high so a button held through reset is not an event.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev_r <= 4'b1111;
    end else begin
      btn_prev_r <= btn_s;
    end
  end

  // Rising-edge events reduced to a single action: cancel > ok > back > next.
  always_comb begin
    ev_s         = btn_s & ~btn_prev_r;
    act_cancel_s = ev_s[3];
    act_ok_s     = ev_s[2] & ~ev_s[3];
    act_back_s   = ev_s[1] & ~(|ev_s[3:2]);
    act_next_s   = ev_s[0] & ~(|ev_s[3:1]);
  end

  // Entry FSM state and highlighted product register.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_state_r <= E_IDLE;
      sel_r     <= {SW{1'b0}};
      reject_r  <= 1'b0;
    end else begin
      e_state_r <= e_state_next_s;
      sel_r     <= sel_next_s;
      reject_r  <= reject_s;
    end
  end

  // Entry FSM next state and next highlighted product.
  always_comb begin
    e_state_next_s = e_state_r;
    sel_next_s     = sel_r;
    case (e_state_r)
      E_IDLE: begin
        if (act_next_s) begin
          e_state_next_s = E_SELECT;
          sel_next_s     = {SW{1'b0}};
        end else begin
          e_state_next_s = E_IDLE;
        end
      end
      E_SELECT: begin
        if (act_cancel_s) begin
          e_state_next_s = E_IDLE;
        end else if (act_ok_s) begin
          e_state_next_s = E_CONFIRM;
        end else if (act_back_s) begin
          sel_next_s = SW'(wrap_step(32'(sel_r), PRODUCTS, 1'b1));
        end else if (act_next_s) begin
          sel_next_s = SW'(wrap_step(32'(sel_r), PRODUCTS, 1'b0));
        end else begin
          e_state_next_s = E_SELECT;
        end
      end
      E_CONFIRM: begin
        if (act_cancel_s || act_back_s) begin
          e_state_next_s = E_SELECT;
        end else if (act_ok_s && !fifo_full_s) begin
          e_state_next_s = E_IDLE;
        end else begin
          e_state_next_s = E_CONFIRM;
        end
      end
      default: begin
        e_state_next_s = E_IDLE;
        sel_next_s     = {SW{1'b0}};
      end
    endcase
  end

  // Entry FSM outputs: queue push on confirmed ok, reject when the queue is full.
  always_comb begin
    push_s   = 1'b0;
    reject_s = 1'b0;
    if ((e_state_r == E_CONFIRM) && act_ok_s) begin
      push_s   = ~fifo_full_s;
      reject_s = fifo_full_s;
    end else begin
      push_s   = 1'b0;
      reject_s = 1'b0;
    end
  end

  cola_pedidos #(
    .DEPTH (DEPTH),
    .W     (SW)
  ) u_cola (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (sel_r),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .full  (fifo_full_s)
  );

  // Delivery FSM state, dispense timer and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_state_r     <= D_IDLE;
      d_cnt_r       <= {CW{1'b0}};
      disp_prod_r   <= {SW{1'b0}};
      disp_active_r <= 1'b0;
      order_done_r  <= 1'b0;
    end else begin
      d_state_r     <= d_state_next_s;
      d_cnt_r       <= d_cnt_next_s;
      disp_active_r <= (d_state_next_s == D_DISPENSE);
      order_done_r  <= (d_state_next_s == D_DONE);
      if (pop_s) begin
        disp_prod_r <= fifo_dout_s;
      end else begin
        disp_prod_r <= disp_prod_r;
      end
    end
  end

  // Delivery FSM next state; timer counts 0..DISPENSE_CYCLES-1 while dispensing.
  always_comb begin
    d_state_next_s = d_state_r;
    d_cnt_next_s   = d_cnt_r;
    case (d_state_r)
      D_IDLE: begin
        if (fifo_count_s != {QW{1'b0}}) begin
          d_state_next_s = D_DISPENSE;
          d_cnt_next_s   = {CW{1'b0}};
        end else begin
          d_state_next_s = D_IDLE;
        end
      end
      D_DISPENSE: begin
        if (d_cnt_r == CW'(DISPENSE_CYCLES - 1)) begin
          d_state_next_s = D_DONE;
          d_cnt_next_s   = {CW{1'b0}};
        end else begin
          d_cnt_next_s = d_cnt_r + CW'(1);
        end
      end
      D_DONE: begin
        d_state_next_s = D_IDLE;
      end
      default: begin
        d_state_next_s = D_IDLE;
        d_cnt_next_s   = {CW{1'b0}};
      end
    endcase
  end

  // Delivery FSM output: take the queue head when idle and an order is waiting.
  always_comb begin
    if ((d_state_r == D_IDLE) && (fifo_count_s != {QW{1'b0}})) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  assign sel_product      = sel_r;
  assign entry_state      = e_state_r;
  assign queue_count      = fifo_count_s;
  assign queue_full       = fifo_full_s;
  assign dispense_active  = disp_active_r;
  assign dispense_product = disp_prod_r;
  assign order_done       = order_done_r;
  assign reject           = reject_r;

endmodule

// File: tb/tb_despacho_ctrl.sv
// Scoreboard bench for despacho_ctrl: two instances (short and long dispense
// time) share the button inputs; a queue-based reference model predicts state
// and pushes expected dispense/done products, a monitor pops and compares.
module tb_despacho_ctrl;

  localparam int P  = 4;
  localparam int D  = 4;
  localparam int N  = 2;
  localparam int B_NEXT = 0;
  localparam int B_BACK = 1;
  localparam int B_OK   = 2;
  localparam int B_CAN  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_next = 1'b0;
  logic btn_back = 1'b0;
  logic btn_ok = 1'b0;
  logic btn_cancel = 1'b0;

  logic [1:0] sel_o [N];
  logic [1:0] es_o  [N];
  logic [2:0] qc_o  [N];
  logic       qf_o  [N];
  logic       da_o  [N];
  logic [1:0] dp_o  [N];
  logic       od_o  [N];
  logic       rj_o  [N];

  despacho_ctrl #(.PRODUCTS(P), .DEPTH(D), .DISPENSE_CYCLES(8)) u_dut0 (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_back(btn_back),
    .btn_ok(btn_ok), .btn_cancel(btn_cancel), .sel_product(sel_o[0]),
    .entry_state(es_o[0]), .queue_count(qc_o[0]), .queue_full(qf_o[0]),
    .dispense_active(da_o[0]), .dispense_product(dp_o[0]),
    .order_done(od_o[0]), .reject(rj_o[0]));

  despacho_ctrl #(.PRODUCTS(P), .DEPTH(D), .DISPENSE_CYCLES(48)) u_dut1 (
    .clk(clk), .reset(reset), .btn_next(btn_next), .btn_back(btn_back),
    .btn_ok(btn_ok), .btn_cancel(btn_cancel), .sel_product(sel_o[1]),
    .entry_state(es_o[1]), .queue_count(qc_o[1]), .queue_full(qf_o[1]),
    .dispense_active(da_o[1]), .dispense_product(dp_o[1]),
    .order_done(od_o[1]), .reject(rj_o[1]));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  // entry: 0 idle, 1 select, 2 confirm; delivery: 0 idle, 1 dispensing, 2 done
  bit [3:0] m_prev;
  int m_entry  [N];
  int m_sel    [N];
  int m_dstate [N];
  int m_left   [N];
  int m_dprod  [N];
  bit m_done   [N];
  bit m_rej    [N];
  int m_q      [N][$];
  int sb_prod  [N][$];
  int sb_done  [N][$];

  function automatic int dc_of(input int i);
    return (i == 0) ? 8 : 48;
  endfunction

  function automatic void model_step(input logic [3:0] b, input logic r);
    bit [3:0] ev;
    int act;
    bit full;
    bit push;
    bit rej;
    if (r) begin
      m_prev = 4'hF;
      for (int i = 0; i < N; i++) begin
        m_entry[i] = 0; m_sel[i] = 0; m_dstate[i] = 0; m_left[i] = 0;
        m_dprod[i] = 0; m_done[i] = 1'b0; m_rej[i] = 1'b0;
        m_q[i].delete(); sb_prod[i].delete(); sb_done[i].delete();
      end
      return;
    end
    ev = b & ~m_prev;
    m_prev = b;
    if (ev[B_CAN]) act = B_CAN;
    else if (ev[B_OK]) act = B_OK;
    else if (ev[B_BACK]) act = B_BACK;
    else if (ev[B_NEXT]) act = B_NEXT;
    else act = -1;
    for (int i = 0; i < N; i++) begin
      full = (m_q[i].size() == D);
      push = 1'b0;
      rej  = 1'b0;
      case (m_entry[i])
        0: if (act == B_NEXT) begin m_entry[i] = 1; m_sel[i] = 0; end
        1: begin
          if (act == B_CAN) m_entry[i] = 0;
          else if (act == B_OK) m_entry[i] = 2;
          else if (act == B_BACK) m_sel[i] = (m_sel[i] + P - 1) % P;
          else if (act == B_NEXT) m_sel[i] = (m_sel[i] + 1) % P;
        end
        default: begin
          if (act == B_CAN || act == B_BACK) m_entry[i] = 1;
          else if (act == B_OK) begin
            if (full) rej = 1'b1;
            else begin push = 1'b1; m_entry[i] = 0; end
          end
        end
      endcase
      case (m_dstate[i])
        0: if (m_q[i].size() > 0) begin
          m_dprod[i] = m_q[i].pop_front();
          m_dstate[i] = 1;
          m_left[i] = dc_of(i);
          sb_prod[i].push_back(m_dprod[i]);
        end
        1: begin
          m_left[i]--;
          if (m_left[i] == 0) begin
            m_dstate[i] = 2;
            sb_done[i].push_back(m_dprod[i]);
          end
        end
        default: m_dstate[i] = 0;
      endcase
      if (push) m_q[i].push_back(m_sel[i]);
      m_done[i] = (m_dstate[i] == 2);
      m_rej[i]  = rej;
    end
  endfunction

  // ---------------- monitor ----------------
  bit mon_en = 1'b0;
  bit da_prev [N];

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d entry_state", i), int'(es_o[i]), m_entry[i]);
        chk($sformatf("u%0d sel_product", i), int'(sel_o[i]), m_sel[i]);
        chk($sformatf("u%0d queue_count", i), int'(qc_o[i]), m_q[i].size());
        chk($sformatf("u%0d queue_full", i), int'(qf_o[i]), int'(m_q[i].size() == D));
        chk($sformatf("u%0d dispense_active", i), int'(da_o[i]), int'(m_dstate[i] == 1));
        chk($sformatf("u%0d dispense_product", i), int'(dp_o[i]), m_dprod[i]);
        chk($sformatf("u%0d order_done", i), int'(od_o[i]), int'(m_done[i]));
        chk($sformatf("u%0d reject", i), int'(rj_o[i]), int'(m_rej[i]));
        if (da_o[i] && !da_prev[i]) begin
          if (sb_prod[i].size() == 0) chk($sformatf("u%0d unexpected dispense", i), 1, 0);
          else chk($sformatf("u%0d dispense order", i), int'(dp_o[i]), sb_prod[i].pop_front());
        end
        if (od_o[i]) begin
          if (sb_done[i].size() == 0) chk($sformatf("u%0d unexpected order_done", i), 1, 0);
          else chk($sformatf("u%0d done product", i), int'(dp_o[i]), sb_done[i].pop_front());
        end
        da_prev[i] = da_o[i];
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [3:0] b, input logic r);
    @(negedge clk);
    btn_next   = b[B_NEXT];
    btn_back   = b[B_BACK];
    btn_ok     = b[B_OK];
    btn_cancel = b[B_CAN];
    reset      = r;
    model_step(b, r);
  endtask

  task automatic press(input int k);
    logic [3:0] b;
    b = 4'b0000;
    b[k] = 1'b1;
    cyc(b, 1'b0);
    cyc(4'b0000, 1'b0);
  endtask

  task automatic order(input int code);
    press(B_NEXT);
    repeat (code) press(B_NEXT);
    press(B_OK);
    press(B_OK);
  endtask

  task automatic do_reset();
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b0);
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [3:0] rb;
    cyc(4'b0000, 1'b1);
    mon_en = 1'b1;
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b0);

    // basic order: next,next,next,back,ok,ok -> code 1
    press(B_NEXT); press(B_NEXT); press(B_NEXT); press(B_BACK);
    press(B_OK);
    cyc(4'b0100, 1'b0);
    sample();
    chk("basic queue_count after push", int'(qc_o[0]), 1);
    chk("basic entry back to idle", int'(es_o[0]), 0);
    cyc(4'b0000, 1'b0);
    sample();
    chk("basic dispense_active", int'(da_o[0]), 1);
    chk("basic dispense_product", int'(dp_o[0]), 1);
    chk("basic queue drained", int'(qc_o[0]), 0);
    repeat (60) cyc(4'b0000, 1'b0);

    // wrap in both directions
    press(B_NEXT); press(B_NEXT); press(B_NEXT); press(B_NEXT);
    press(B_NEXT);
    chk("wrap up to 0", int'(sel_o[0]), 0);
    press(B_BACK);
    chk("wrap down to 3", int'(sel_o[0]), 3);
    press(B_CAN);

    // queue fill while the long instance is busy; fifth ok rejected
    do_reset();
    order(0);
    cyc(4'b0000, 1'b0);
    order(0); order(1); order(2); order(3);
    chk("fill queue_full long", int'(qf_o[1]), 1);
    press(B_NEXT); press(B_OK);
    cyc(4'b0100, 1'b0);
    sample();
    chk("fill reject pulse", int'(rj_o[1]), 1);
    chk("fill stays confirm", int'(es_o[1]), 2);
    cyc(4'b0000, 1'b0);
    press(B_CAN); press(B_CAN);
    repeat (280) cyc(4'b0000, 1'b0);

    // cancel and ok together in CONFIRM
    press(B_NEXT); press(B_NEXT); press(B_OK);
    cyc(4'b1100, 1'b0);
    sample();
    chk("cancel+ok to select", int'(es_o[0]), 1);
    chk("cancel+ok no push", int'(qc_o[0]), 0);
    cyc(4'b0000, 1'b0);
    press(B_CAN);

    // reset during dispense with orders queued
    do_reset();
    order(1); order(2); order(3);
    cyc(4'b0000, 1'b1);
    sample();
    chk("mid reset dispense_active", int'(da_o[1]), 0);
    chk("mid reset queue_count", int'(qc_o[1]), 0);
    chk("mid reset dispense_product", int'(dp_o[1]), 0);
    cyc(4'b0000, 1'b0);
    repeat (60) cyc(4'b0000, 1'b0);

    // next held through reset release
    cyc(4'b0001, 1'b1);
    cyc(4'b0001, 1'b1);
    repeat (3) cyc(4'b0001, 1'b0);
    chk("held next ignored", int'(es_o[0]), 0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0001, 1'b0);
    sample();
    chk("fresh next to select", int'(es_o[0]), 1);
    cyc(4'b0000, 1'b0);
    press(B_CAN);

    // random buttons with occasional reset
    for (int k = 0; k < 900; k++) begin
      for (int j = 0; j < 4; j++) rb[j] = ($urandom_range(0, 3) == 0);
      cyc(rb, ($urandom_range(0, 299) == 0));
    end
    repeat (320) cyc(4'b0000, 1'b0);
    sample();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("u%0d leftover dispenses", i), sb_prod[i].size(), 0);
      chk($sformatf("u%0d leftover dones", i), sb_done[i].size(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
